music_sequencer: RTL

//   Plays a song stored in the 256x6 note ROM. Steps the ROM address at a fixed tempo and

---
 rtl/music_pkg.sv | 17 +
 rtl/music_step_timer.sv | 32 +++
 rtl/music_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// Shared types and widths for the music sequencer block.
package music_pkg;

    localparam int NOTE_W = 6;
    localparam int ADRS_W = 8;
    localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        PLAY  = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/music_step_timer.sv
// Step timer: counts 0..STEP_CYCLES-3 within one note step and flags the
// final count and the silent gap at the end of the step.
module music_step_timer #(
    parameter int STEP_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int CNT_W       = $clog2(STEP_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             gap
);

    assign last = (cnt == CNT_W'(STEP_CYCLES - 3));
    assign gap  = (cnt >= CNT_W'(STEP_CYCLES - 2 - GAP_CYCLES));

    // Step counter: cleared outside playback, frozen when run is low, wraps after the last count.
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// Music sequencer: walks the note ROM at a fixed tempo, absorbs the ROM's
// one-cycle read latency, mutes a short gap at the end of every step and
// obeys play/pause/stop commands (priority stop > pause > play).
// Optional feature: define MUSIC_SEQ_LOOP_EN to add the `loop` input, which
// restarts the song at address 0 instead of finishing in DONE.
module music_sequencer
    import music_pkg::*;
#(
    parameter int STEP_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int SONG_LEN    = 241
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
`ifdef MUSIC_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic [ADRS_W-1:0] rom_adrs,
    input  logic [NOTE_W-1:0] rom_note,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              step_stb,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(STEP_CYCLES);

    seq_state_t       state;
    logic             pause_pend;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             gap;
    logic             pause_now;
    logic             last_adrs;
    logic             timer_clr;
    logic             timer_run;

    // A pause requested during FETCH/LATCH takes effect on the first PLAY cycle (cnt is 0 there).
    assign pause_now = pause || (pause_pend && (cnt == '0));
    assign last_adrs = (rom_adrs == ADRS_W'(SONG_LEN - 1));
    assign timer_clr = stop || !((state == PLAY) || (state == PAUSE));
    assign timer_run = (state == PLAY) && !pause_now;

    assign busy = (state == FETCH) || (state == LATCH) || (state == PLAY) || (state == PAUSE);
    assign done = (state == DONE);

    music_step_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .run   (timer_run),
        .cnt   (cnt),
        .last  (last),
        .gap   (gap)
    );

    // Sequencer FSM with registered address, note and tone-enable outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rom_adrs   <= '0;
            note_out   <= NOTE_REST;
            note_valid <= 1'b0;
            step_stb   <= 1'b0;
            pause_pend <= 1'b0;
        end else begin
            // NOTE: default assignment first so step_stb is a single-cycle pulse unless a branch sets it.
            step_stb <= 1'b0;
            if (stop) begin
                state      <= IDLE;
                rom_adrs   <= '0;
                note_out   <= NOTE_REST;
                note_valid <= 1'b0;
                pause_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (play && !pause) begin
                            state    <= FETCH;
                            rom_adrs <= '0;
                        end
                    end
                    FETCH: begin
                        if (pause) pause_pend <= 1'b1;
                        state <= LATCH;
                    end
                    LATCH: begin
                        if (pause) pause_pend <= 1'b1;
                        note_out   <= rom_note;
                        step_stb   <= 1'b1;
                        // First PLAY cycle has cnt=0, which is always before the gap.
                        note_valid <= (rom_note != NOTE_REST) && !pause && !pause_pend;
                        state      <= PLAY;
                    end
                    PLAY: begin
                        if (pause_now) begin
                            state      <= PAUSE;
                            note_valid <= 1'b0;
                            pause_pend <= 1'b0;
                        end else if (last) begin
                            note_valid <= 1'b0;
                            if (last_adrs) begin
`ifdef MUSIC_SEQ_LOOP_EN
                                if (loop) begin
                                    rom_adrs <= '0;
                                    state    <= FETCH;
                                end else begin
                                    state    <= DONE;
                                    note_out <= NOTE_REST;
                                end
`else
                                state    <= DONE;
                                note_out <= NOTE_REST;
`endif
                            end else begin
                                rom_adrs <= rom_adrs + ADRS_W'(1);
                                state    <= FETCH;
                            end
                        end else begin
                            // Value for the next cycle, whose count is cnt+1.
                            note_valid <= (note_out != NOTE_REST) &&
                                          (cnt < CNT_W'(STEP_CYCLES - 3 - GAP_CYCLES));
                        end
                    end
                    PAUSE: begin
                        if (play && !pause) begin
                            state      <= PLAY;
                            note_valid <= (note_out != NOTE_REST) && !gap;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
